// File: rtl/hazard_pkg.sv
// Shared encodings for the pipeline hazard unit: forwarding selects,
// memory-wait FSM states and the stall/flush control bundle.
package hazard_pkg;

   localparam logic [1:0] FWD_RF = 2'b00;
   localparam logic [1:0] FWD_W  = 2'b01;
   localparam logic [1:0] FWD_M  = 2'b10;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } memState_t;

   typedef struct packed {
      logic stallF;
      logic stallD;
      logic stallE;
      logic stallM;
      logic flushD;
      logic flushE;
      logic flushW;
   } pipeCtrl_t;

endpackage

// File: rtl/hazard_unit_param_fwd_sel.sv
// Per-operand address matching: execute-stage forward select and
// decode-stage load-use match against the E and M destinations.
module fwd_sel
   import hazard_pkg::*;
#(
   parameter int unsigned RA_W = 4
)
(
   input  logic [RA_W-1:0] raE,
   input  logic            raValidE,
   input  logic [RA_W-1:0] raD,
   input  logic            raValidD,
   input  logic [RA_W-1:0] wa3E,
   input  logic [RA_W-1:0] wa3M,
   input  logic [RA_W-1:0] wa3W,
   input  logic            regWriteM,
   input  logic            regWriteW,
   output logic [1:0]      forward,
   output logic            matchDE,
   output logic            matchDM
);

   logic hitM;
   logic hitW;

   assign hitM = raValidE && regWriteM && (raE == wa3M);
   assign hitW = raValidE && regWriteW && (raE == wa3W);

   // The younger M result shadows the W result for the same register.
   assign forward = hitM ? FWD_M : (hitW ? FWD_W : FWD_RF);

   assign matchDE = raValidD && (raD == wa3E);
   assign matchDM = raValidD && (raD == wa3M);

endmodule

// File: rtl/hazard_unit_param.sv
// Pipeline hazard unit: operand forwarding, load-use and memory-wait stalls,
// control-flow flushes, and saturating stall/flush statistics counters.
module hazard_unit_param
   import hazard_pkg::*;
#(
   parameter int unsigned NSRC  = 3,
   parameter int unsigned RA_W  = 4,
   parameter int unsigned CNT_W = 16
)
(
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NSRC*RA_W-1:0] RA_D,
   input  logic [NSRC*RA_W-1:0] RA_E,
   input  logic [NSRC-1:0]      RAValid_D,
   input  logic [NSRC-1:0]      RAValid_E,
   input  logic [RA_W-1:0]      WA3E,
   input  logic [RA_W-1:0]      WA3M,
   input  logic [RA_W-1:0]      WA3W,
   input  logic                 RegWriteE,
   input  logic                 RegWriteM,
   input  logic                 RegWriteW,
   input  logic                 MemtoRegE,
   input  logic                 MemtoRegM,
   input  logic                 MemReadyM,
   input  logic                 PCSrcD,
   input  logic                 PCSrcE,
   input  logic                 PCSrcM,
   input  logic                 PCSrcW,
   input  logic                 BranchTakenE,
   output logic [2*NSRC-1:0]    ForwardE,
   output logic                 StallF,
   output logic                 StallD,
   output logic                 StallE,
   output logic                 StallM,
   output logic                 FlushD,
   output logic                 FlushE,
   output logic                 FlushW,
   output logic [CNT_W-1:0]     StallCount,
   output logic [CNT_W-1:0]     FlushCount
);

   memState_t       memState;
   pipeCtrl_t       ctrl;
   logic [NSRC-1:0] matchDE;
   logic [NSRC-1:0] matchDM;
   logic            ldUseStall;
   logic            memStall;
   logic            memNotReady;
   logic            pcWrPendingF;

   for (genvar i = 0; i < NSRC; i++) begin : g_fwd
      fwd_sel #(
         .RA_W (RA_W)
      ) u_fwd_sel (
         .raE       (RA_E[i*RA_W +: RA_W]),
         .raValidE  (RAValid_E[i]),
         .raD       (RA_D[i*RA_W +: RA_W]),
         .raValidD  (RAValid_D[i]),
         .wa3E      (WA3E),
         .wa3M      (WA3M),
         .wa3W      (WA3W),
         .regWriteM (RegWriteM),
         .regWriteW (RegWriteW),
         .forward   (ForwardE[2*i +: 2]),
         .matchDE   (matchDE[i]),
         .matchDM   (matchDM[i])
      );
   end

   // A load in M is still outstanding while waiting, even on the cycle ready arrives.
   assign memNotReady  = (memState == WAIT) || !MemReadyM;
   assign ldUseStall   = ((|matchDE) && MemtoRegE && RegWriteE) ||
                         ((|matchDM) && MemtoRegM && memNotReady);
   assign memStall     = MemtoRegM && !MemReadyM;
   assign pcWrPendingF = PCSrcD || PCSrcE || PCSrcM;

   // Memory stall freezes the whole pipe and overrides every other cause.
   always_comb begin
      ctrl = '0;
      if (memStall) begin
         ctrl.stallF = 1'b1;
         ctrl.stallD = 1'b1;
         ctrl.stallE = 1'b1;
         ctrl.stallM = 1'b1;
         ctrl.flushW = 1'b1;
      end else begin
         ctrl.stallF = ldUseStall || pcWrPendingF;
         ctrl.stallD = ldUseStall;
         ctrl.flushD = pcWrPendingF || PCSrcW || BranchTakenE;
         ctrl.flushE = ldUseStall || BranchTakenE;
      end
   end

   assign StallF = ctrl.stallF;
   assign StallD = ctrl.stallD;
   assign StallE = ctrl.stallE;
   assign StallM = ctrl.stallM;
   assign FlushD = ctrl.flushD;
   assign FlushE = ctrl.flushE;
   assign FlushW = ctrl.flushW;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         memState <= IDLE;
      end else begin
         case (memState)
            IDLE:    if (MemtoRegM && !MemReadyM) memState <= WAIT;
            WAIT:    if (MemReadyM)               memState <= IDLE;
            default:                              memState <= IDLE;
         endcase
      end
   end

   // Saturating statistics; a count sticks at all-ones instead of wrapping.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         StallCount <= '0;
         FlushCount <= '0;
      end else begin
         if (ctrl.stallF && !(&StallCount)) begin
            StallCount <= StallCount + CNT_W'(1);
         end
         if ((ctrl.flushD || ctrl.flushE || ctrl.flushW) && !(&FlushCount)) begin
            FlushCount <= FlushCount + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_hazard_unit_param.sv
// Scoreboard bench for hazard_unit_param: a behavioural model predicts each
// cycle's outputs, which are queued on drive and compared at the falling edge.
module tb_hazard_unit_param;

   localparam int unsigned NSRC = 3;
   localparam int unsigned RA_W = 4;

   logic clk;
   logic reset;
   logic [NSRC*RA_W-1:0] RA_D, RA_E;
   logic [NSRC-1:0] RAValid_D, RAValid_E;
   logic [RA_W-1:0] WA3E, WA3M, WA3W;
   logic RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM, MemReadyM;
   logic PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE;

   logic [2*NSRC-1:0] ForwardE, ForwardE4;
   logic StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
   logic StallF4, StallD4, StallE4, StallM4, FlushD4, FlushE4, FlushW4;
   logic [15:0] StallCount, FlushCount;
   logic [3:0]  StallCount4, FlushCount4;

   typedef struct {
      logic [5:0]  fwd;
      logic [6:0]  ctl;  // {sF,sD,sE,sM,fD,fE,fW}
      logic [15:0] sc;
      logic [15:0] fc;
      logic [3:0]  sc4;
      logic [3:0]  fc4;
   } exp_t;

   exp_t sbQ[$];
   int   passCnt  = 0;
   int   totalCnt = 0;
   bit   mWait;
   int   mSc, mFc, mSc4, mFc4;

   hazard_unit_param u_dut (
      .clk(clk), .reset(reset), .RA_D(RA_D), .RA_E(RA_E),
      .RAValid_D(RAValid_D), .RAValid_E(RAValid_E),
      .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
      .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
      .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM), .MemReadyM(MemReadyM),
      .PCSrcD(PCSrcD), .PCSrcE(PCSrcE), .PCSrcM(PCSrcM), .PCSrcW(PCSrcW),
      .BranchTakenE(BranchTakenE), .ForwardE(ForwardE),
      .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
      .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
      .StallCount(StallCount), .FlushCount(FlushCount)
   );

   hazard_unit_param #(.NSRC(3), .RA_W(4), .CNT_W(4)) u_dut4 (
      .clk(clk), .reset(reset), .RA_D(RA_D), .RA_E(RA_E),
      .RAValid_D(RAValid_D), .RAValid_E(RAValid_E),
      .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
      .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
      .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM), .MemReadyM(MemReadyM),
      .PCSrcD(PCSrcD), .PCSrcE(PCSrcE), .PCSrcM(PCSrcM), .PCSrcW(PCSrcW),
      .BranchTakenE(BranchTakenE), .ForwardE(ForwardE4),
      .StallF(StallF4), .StallD(StallD4), .StallE(StallE4), .StallM(StallM4),
      .FlushD(FlushD4), .FlushE(FlushE4), .FlushW(FlushW4),
      .StallCount(StallCount4), .FlushCount(FlushCount4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
      totalCnt++;
      if (got === exp) passCnt++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   function automatic logic [RA_W-1:0] opD(input int i);
      return RA_D[i*RA_W +: RA_W];
   endfunction

   function automatic logic [RA_W-1:0] opE(input int i);
      return RA_E[i*RA_W +: RA_W];
   endfunction

   function automatic exp_t predict();
      exp_t e;
      logic ld, ms, pc;
      e.fwd = '0;
      for (int i = 0; i < NSRC; i++) begin
         if (RAValid_E[i] && RegWriteM && opE(i) == WA3M)      e.fwd[2*i +: 2] = 2'b10;
         else if (RAValid_E[i] && RegWriteW && opE(i) == WA3W) e.fwd[2*i +: 2] = 2'b01;
      end
      ld = 1'b0;
      for (int i = 0; i < NSRC; i++) begin
         if (RAValid_D[i] && opD(i) == WA3E && MemtoRegE && RegWriteE) ld = 1'b1;
         if (RAValid_D[i] && opD(i) == WA3M && MemtoRegM && (mWait || !MemReadyM)) ld = 1'b1;
      end
      ms = MemtoRegM && !MemReadyM;
      pc = PCSrcD || PCSrcE || PCSrcM;
      if (ms) e.ctl = 7'b1111_001;
      else    e.ctl = {ld || pc, ld, 1'b0, 1'b0, pc || PCSrcW || BranchTakenE, ld || BranchTakenE, 1'b0};
      e.sc  = 16'(mSc);
      e.fc  = 16'(mFc);
      e.sc4 = 4'(mSc4);
      e.fc4 = 4'(mFc4);
      return e;
   endfunction

   task automatic compareOut();
      exp_t e;
      e = sbQ.pop_front();
      checkVal("fwd",    32'(ForwardE), 32'(e.fwd));
      checkVal("ctl",    32'({StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}), 32'(e.ctl));
      checkVal("fwd4",   32'(ForwardE4), 32'(e.fwd));
      checkVal("ctl4",   32'({StallF4, StallD4, StallE4, StallM4, FlushD4, FlushE4, FlushW4}), 32'(e.ctl));
      checkVal("sCnt",   32'(StallCount), 32'(e.sc));
      checkVal("fCnt",   32'(FlushCount), 32'(e.fc));
      checkVal("sCnt4",  32'(StallCount4), 32'(e.sc4));
      checkVal("fCnt4",  32'(FlushCount4), 32'(e.fc4));
   endtask

   task automatic advance(input exp_t e);
      if (e.ctl[6]) begin
         if (mSc  < 65535) mSc++;
         if (mSc4 < 15)    mSc4++;
      end
      if (e.ctl[2] || e.ctl[1] || e.ctl[0]) begin
         if (mFc  < 65535) mFc++;
         if (mFc4 < 15)    mFc4++;
      end
      if (!mWait && MemtoRegM && !MemReadyM) mWait = 1'b1;
      else if (mWait && MemReadyM)           mWait = 1'b0;
   endtask

   // One cycle: predict, queue, compare at the falling edge, advance model.
   task automatic step();
      exp_t e;
      e = predict();
      sbQ.push_back(e);
      @(negedge clk);
      compareOut();
      advance(e);
      @(posedge clk);
      #1;
   endtask

   task automatic clearInputs();
      RA_D = '0; RA_E = '0; RAValid_D = '0; RAValid_E = '0;
      WA3E = '0; WA3M = '0; WA3W = '0;
      RegWriteE = 0; RegWriteM = 0; RegWriteW = 0;
      MemtoRegE = 0; MemtoRegM = 0; MemReadyM = 1;
      PCSrcD = 0; PCSrcE = 0; PCSrcM = 0; PCSrcW = 0; BranchTakenE = 0;
   endtask

   task automatic modelReset();
      mWait = 1'b0; mSc = 0; mFc = 0; mSc4 = 0; mFc4 = 0;
   endtask

   task automatic doReset();
      reset = 1'b0;
      modelReset();
      @(posedge clk);
      #1;
      reset = 1'b1;
   endtask

   initial begin
      clearInputs();
      reset = 1'b0;
      modelReset();
      #2;
      checkVal("rst_sCnt", 32'(StallCount), 32'd0);
      checkVal("rst_fCnt", 32'(FlushCount), 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      step();

      // Forwarding: M wins over W, then W only, then invalid operands.
      RA_E = {4'd7, 4'd3, 4'd3}; RAValid_E = 3'b111;
      WA3M = 4'd3; RegWriteM = 1; WA3W = 4'd3; RegWriteW = 1;
      #1;
      checkVal("fwd_m_prio", 32'(ForwardE[3:0]), 32'h0000000a);
      step();
      RegWriteM = 0; step();
      RAValid_E = 3'b100; step();
      RA_E = {4'd3, 4'd1, 4'd2}; RAValid_E = 3'b111; WA3M = 4'd2; RegWriteM = 1; WA3W = 4'd3;
      step();

      // Load-use from E.
      clearInputs();
      MemtoRegE = 1; RegWriteE = 1; WA3E = 4'd5;
      RA_D = {4'd5, 4'd0, 4'd0}; RAValid_D = 3'b100;
      #1;
      checkVal("ldE_stall", 32'({StallF, StallD, FlushE}), 32'h7);
      step();
      RAValid_D = 3'b011;
      #1;
      checkVal("ldE_nostall", 32'({StallF, StallD}), 32'h0);
      step();

      // Memory wait: three not-ready cycles, then ready.
      clearInputs();
      doReset();
      MemtoRegM = 1; MemReadyM = 0; WA3M = 4'd9; RegWriteM = 1;
      for (int k = 0; k < 3; k++) begin
         #1;
         checkVal("mem_stall", 32'({StallF, StallD, StallE, StallM, FlushW, FlushD, FlushE}), 32'h7c);
         step();
      end
      MemReadyM = 1; RA_D = {4'd0, 4'd0, 4'd9}; RAValid_D = 3'b001;
      #1;
      checkVal("mem_cnt3", 32'(StallCount), 32'd3);
      checkVal("wait_ldUse", 32'({StallD, StallM}), 32'h2);
      step();
      #1;
      checkVal("idle_noLdUse", 32'(StallD), 32'd0);
      step();

      // Branch together with load-use, then a clean cycle.
      clearInputs();
      MemtoRegE = 1; RegWriteE = 1; WA3E = 4'd2;
      RA_D = {4'd0, 4'd0, 4'd2}; RAValid_D = 3'b001; BranchTakenE = 1;
      #1;
      checkVal("br_ld", 32'({FlushD, FlushE, StallD}), 32'h7);
      step();
      clearInputs();
      #1;
      checkVal("br_clean", 32'({FlushD, FlushE, FlushW}), 32'h0);
      step();

      // Saturation of the narrow counters.
      PCSrcD = 1;
      for (int k = 0; k < 20; k++) step();
      checkVal("sat_sCnt4", 32'(StallCount4), 32'd15);
      step();
      checkVal("sat_hold4", 32'(StallCount4), 32'd15);
      clearInputs();

      // Asynchronous reset while waiting on memory.
      MemtoRegM = 1; MemReadyM = 0; WA3M = 4'd6; RegWriteM = 1;
      step();
      step();
      #2;
      reset = 1'b0;
      #1;
      checkVal("arst_sCnt", 32'(StallCount), 32'd0);
      checkVal("arst_fCnt", 32'(FlushCount), 32'd0);
      checkVal("arst_sCnt4", 32'(StallCount4), 32'd0);
      MemReadyM = 1; RA_D = {4'd0, 4'd0, 4'd6}; RAValid_D = 3'b001;
      #1;
      checkVal("arst_idle", 32'({StallF, StallD}), 32'h0);
      MemReadyM = 0;
      #1;
      checkVal("arst_memStall", 32'({StallF, StallM, FlushW}), 32'h7);
      modelReset();
      clearInputs();
      @(posedge clk);
      #1;
      reset = 1'b1;
      PCSrcE = 1;
      step();
      step();

      // Random mix.
      for (int k = 0; k < 60; k++) begin
         RA_D = NSRC*RA_W'({$urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3)});
         RA_E = NSRC*RA_W'({$urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3)});
         RAValid_D = 3'($urandom); RAValid_E = 3'($urandom);
         WA3E = 4'($urandom_range(0, 3)); WA3M = 4'($urandom_range(0, 3)); WA3W = 4'($urandom_range(0, 3));
         RegWriteE = 1'($urandom); RegWriteM = 1'($urandom); RegWriteW = 1'($urandom);
         MemtoRegE = 1'($urandom); MemtoRegM = 1'($urandom);
         MemReadyM = ($urandom_range(0, 3) != 0);
         PCSrcD = ($urandom_range(0, 7) == 0); PCSrcE = ($urandom_range(0, 7) == 0);
         PCSrcM = ($urandom_range(0, 7) == 0); PCSrcW = ($urandom_range(0, 7) == 0);
         BranchTakenE = ($urandom_range(0, 5) == 0);
         step();
      end

      $display("%0d/%0d checks passed", passCnt, totalCnt);
      $finish;
   end

endmodule
